// File: rtl/game_pkg.sv
// Shared game definitions: screen geometry, coordinate width, slot state
// encoding and small helpers used by the obstacle logic.
package game_pkg;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;
  localparam int unsigned COORD_W  = 10;

  // Galois feedback mask for x^16+x^14+x^13+x^11+1 (right-shifting form).
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    SLOT_IDLE   = 2'd0,
    SLOT_MOVING = 2'd1,
    SLOT_HIT    = 2'd2
  } slot_state_t;

  // Number of set bits in an 8-bit vector.
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      n = n + 4'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/obstacle_slot.sv
// One obstacle slot: IDLE/MOVING/HIT state machine, position, vertical
// direction and hit hold timer.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   tick_i          game tick (already gated by pause)
//   spawn_i         load spawn position and start moving (only when IDLE)
//   spawn_y_i       Y coordinate for a spawn
//   collision_i     collision flag from the detector
//   state_o         current slot state
//   active_o/hit_o  registered MOVING-or-HIT / HIT flags
//   x_o, y_o        registered position
//   enter_hit_c     combinational: slot enters HIT on this tick
module obstacle_slot
  import game_pkg::*;
#(
  parameter logic [COORD_W-1:0] OBS_WIDTH        = 10'd30,
  parameter logic [COORD_W-1:0] X_SPEED          = 10'd5,
  parameter logic [COORD_W-1:0] Y_INITIAL_OFFSET = 10'd50,
  parameter logic [COORD_W-1:0] Y_AMPLITUDE      = 10'd60,
  parameter int unsigned        HIT_HOLD         = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick_i,
  input  logic               spawn_i,
  input  logic [COORD_W-1:0] spawn_y_i,
  input  logic               collision_i,
  output slot_state_t        state_o,
  output logic               active_o,
  output logic               hit_o,
  output logic [COORD_W-1:0] x_o,
  output logic [COORD_W-1:0] y_o,
  output logic               enter_hit_c
);

  localparam int unsigned        HOLD_W    = (HIT_HOLD > 1) ? $clog2(HIT_HOLD) : 1;
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HIT_HOLD - 1);
  localparam logic [COORD_W-1:0] SPAWN_X   = COORD_W'(SCREEN_W) - OBS_WIDTH;
  localparam logic [COORD_W-1:0] Y_TOP     = Y_INITIAL_OFFSET;
  localparam logic [COORD_W-1:0] Y_BOT     = Y_INITIAL_OFFSET + Y_AMPLITUDE;

  slot_state_t        state_q, state_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic               dir_q, dir_d;     // 1 = down (y increasing)
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               active_q, active_d;
  logic               hit_q, hit_d;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= SLOT_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      dir_q    <= 1'b1;
      hold_q   <= '0;
      active_q <= 1'b0;
      hit_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      dir_q    <= dir_d;
      hold_q   <= hold_d;
      active_q <= active_d;
      hit_q    <= hit_d;
    end
  end

  // Next-state, motion and hold timer.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    dir_d       = dir_q;
    hold_d      = hold_q;
    enter_hit_c = 1'b0;

    case (state_q)
      SLOT_IDLE: begin
        if (spawn_i) begin
          state_d = SLOT_MOVING;
          x_d     = SPAWN_X;
          y_d     = spawn_y_i;
          dir_d   = 1'b1;
        end
      end

      SLOT_MOVING: begin
        if (tick_i) begin
          // Collision wins over a simultaneous left-edge exit.
          if (collision_i) begin
            state_d     = SLOT_HIT;
            hold_d      = '0;
            enter_hit_c = 1'b1;
          end else if (x_q < X_SPEED) begin
            state_d = SLOT_IDLE;
            x_d     = '0;
            y_d     = '0;
            dir_d   = 1'b1;
          end else begin
            x_d = x_q - X_SPEED;
            // At a band edge the reversed step is applied on this same tick.
            if (dir_q) begin
              if (y_q >= Y_BOT) begin
                dir_d = 1'b0;
                y_d   = y_q - COORD_W'(1);
              end else begin
                y_d = y_q + COORD_W'(1);
              end
            end else begin
              if (y_q <= Y_TOP) begin
                dir_d = 1'b1;
                y_d   = y_q + COORD_W'(1);
              end else begin
                y_d = y_q - COORD_W'(1);
              end
            end
          end
        end
      end

      SLOT_HIT: begin
        if (tick_i) begin
          if (hold_q == HOLD_LAST) begin
            state_d = SLOT_IDLE;
            hold_d  = '0;
            x_d     = '0;
            y_d     = '0;
            dir_d   = 1'b1;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
      end

      default: begin
        state_d = SLOT_IDLE;
      end
    endcase

    active_d = (state_d != SLOT_IDLE);
    hit_d    = (state_d == SLOT_HIT);
  end

  assign state_o  = state_q;
  assign active_o = active_q;
  assign hit_o    = hit_q;
  assign x_o      = x_q;
  assign y_o      = y_q;

endmodule

// File: rtl/obstacle_array_control.sv
// Obstacle array controller: spawn timing, random spawn height, slot
// arbitration and hit accounting around NUM_OBS obstacle_slot instances.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   game_en        one-clk game tick strobe
//   pause          suppresses game ticks while high
//   collision_vec  per-slot collision flags
//   obs_active     slot is MOVING or HIT
//   obs_hit        slot is HIT
//   obs_x, obs_y   packed 10-bit positions, slot i at [10i+9:10i]
//   hit_pulse      one-clk strobe after a tick where any slot entered HIT
//   hit_count      saturating cumulative hit count
module obstacle_array_control
  import game_pkg::*;
#(
  parameter int unsigned        NUM_OBS          = 4,
  parameter logic [COORD_W-1:0] OBS_WIDTH        = 10'd30,
  parameter logic [COORD_W-1:0] X_SPEED          = 10'd5,
  parameter logic [COORD_W-1:0] Y_INITIAL_OFFSET = 10'd50,
  parameter logic [COORD_W-1:0] Y_AMPLITUDE      = 10'd60,
  parameter int unsigned        Y_RANGE_LOG2     = 6,
  parameter int unsigned        SPAWN_INTERVAL   = 64,
  parameter int unsigned        HIT_HOLD         = 8,
  parameter logic [15:0]        LFSR_SEED        = 16'hACE1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         game_en,
  input  logic                         pause,
  input  logic [NUM_OBS-1:0]           collision_vec,
  output logic [NUM_OBS-1:0]           obs_active,
  output logic [NUM_OBS-1:0]           obs_hit,
  output logic [NUM_OBS*COORD_W-1:0]   obs_x,
  output logic [NUM_OBS*COORD_W-1:0]   obs_y,
  output logic                         hit_pulse,
  output logic [7:0]                   hit_count
);

  localparam int unsigned        CNT_W    = (SPAWN_INTERVAL > 1) ? $clog2(SPAWN_INTERVAL) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SPAWN_INTERVAL - 1);
  localparam logic [COORD_W-1:0] Y_BOT    = Y_INITIAL_OFFSET + Y_AMPLITUDE;

  logic               tick_c;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic               hit_pulse_q, hit_pulse_d;
  logic [7:0]         hit_count_q, hit_count_d;

  logic               spawn_attempt_c;
  logic               found_c;
  logic [NUM_OBS-1:0] spawn_vec_c;
  logic [NUM_OBS-1:0] enter_vec_c;
  logic [COORD_W-1:0] y_sum_c;
  logic [COORD_W-1:0] spawn_y_c;
  logic [8:0]         count_sum_c;
  slot_state_t        slot_state [NUM_OBS];

  assign tick_c = game_en & ~pause;

  // Controller registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      lfsr_q      <= LFSR_SEED;
      hit_pulse_q <= 1'b0;
      hit_count_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      lfsr_q      <= lfsr_d;
      hit_pulse_q <= hit_pulse_d;
      hit_count_q <= hit_count_d;
    end
  end

  // Spawn counter and LFSR advance only on ticks.
  always_comb begin
    cnt_d           = cnt_q;
    lfsr_d          = lfsr_q;
    spawn_attempt_c = 1'b0;
    if (tick_c) begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
      if (cnt_q == CNT_LAST) begin
        cnt_d           = '0;
        spawn_attempt_c = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Lowest-index IDLE slot in the pre-tick state takes the spawn; none means drop.
  always_comb begin
    spawn_vec_c = '0;
    found_c     = 1'b0;
    for (int unsigned i = 0; i < NUM_OBS; i++) begin
      if (!found_c && slot_state[i] == SLOT_IDLE) begin
        spawn_vec_c[i] = spawn_attempt_c;
        found_c        = 1'b1;
      end
    end
  end

  // Spawn height from the current LFSR value, clamped to the band bottom.
  always_comb begin
    y_sum_c   = Y_INITIAL_OFFSET + COORD_W'(lfsr_q[Y_RANGE_LOG2-1:0]);
    spawn_y_c = (y_sum_c > Y_BOT) ? Y_BOT : y_sum_c;
  end

  // Hit strobe and saturating hit counter.
  always_comb begin
    count_sum_c = 9'(hit_count_q) + 9'(popcount8(8'(enter_vec_c)));
    hit_count_d = count_sum_c[8] ? 8'hFF : count_sum_c[7:0];
    hit_pulse_d = |enter_vec_c;
  end

  for (genvar i = 0; i < NUM_OBS; i++) begin : g_slot
    obstacle_slot #(
      .OBS_WIDTH        (OBS_WIDTH),
      .X_SPEED          (X_SPEED),
      .Y_INITIAL_OFFSET (Y_INITIAL_OFFSET),
      .Y_AMPLITUDE      (Y_AMPLITUDE),
      .HIT_HOLD         (HIT_HOLD)
    ) u_slot (
      .clk         (clk),
      .rst         (rst),
      .tick_i      (tick_c),
      .spawn_i     (spawn_vec_c[i]),
      .spawn_y_i   (spawn_y_c),
      .collision_i (collision_vec[i]),
      .state_o     (slot_state[i]),
      .active_o    (obs_active[i]),
      .hit_o       (obs_hit[i]),
      .x_o         (obs_x[COORD_W*i +: COORD_W]),
      .y_o         (obs_y[COORD_W*i +: COORD_W]),
      .enter_hit_c (enter_vec_c[i])
    );
  end

  assign hit_pulse = hit_pulse_q;
  assign hit_count = hit_count_q;

endmodule

// File: tb/tb_obstacle_array_control.sv
// Directed bench for obstacle_array_control: a default instance plus a
// fast-spawn, slow-moving instance used to fill the array and saturate hits.
module tb_obstacle_array_control;

  logic        clk;
  logic        rst;
  logic        game_en;
  logic        pause;
  logic [3:0]  collision_vec;

  logic [3:0]  obs_active, obs_hit;
  logic [39:0] obs_x, obs_y;
  logic        hit_pulse;
  logic [7:0]  hit_count;

  logic [3:0]  b_active, b_hit;
  logic [39:0] b_x, b_y;
  logic        b_pulse;
  logic [7:0]  b_count;

  int          tests_run;
  int          tests_failed;
  logic [15:0] lfsr_m;

  obstacle_array_control dut (
    .clk(clk), .rst(rst), .game_en(game_en), .pause(pause),
    .collision_vec(collision_vec), .obs_active(obs_active), .obs_hit(obs_hit),
    .obs_x(obs_x), .obs_y(obs_y), .hit_pulse(hit_pulse), .hit_count(hit_count)
  );

  obstacle_array_control #(.X_SPEED(10'd1), .SPAWN_INTERVAL(4)) dut_fast (
    .clk(clk), .rst(rst), .game_en(game_en), .pause(pause),
    .collision_vec(collision_vec), .obs_active(b_active), .obs_hit(b_hit),
    .obs_x(b_x), .obs_y(b_y), .hit_pulse(b_pulse), .hit_count(b_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic int spawn_y(input logic [15:0] l);
    int t;
    t = 50 + int'(l[5:0]);
    return (t > 110) ? 110 : t;
  endfunction

  // Expected y after n moving ticks from a fresh spawn (direction down).
  function automatic int bounce_y(input int y0, input int n);
    int y;
    bit d;
    y = y0;
    d = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (d) begin
        if (y >= 110) begin d = 1'b0; y = y - 1; end else y = y + 1;
      end else begin
        if (y <= 50) begin d = 1'b1; y = y + 1; end else y = y - 1;
      end
    end
    return y;
  endfunction

  task automatic do_tick(input logic [3:0] col);
    collision_vec = col;
    game_en       = 1'b1;
    @(negedge clk);
    game_en       = 1'b0;
    if (!pause) lfsr_m = lfsr_step(lfsr_m);
  endtask

  task automatic ticks(input int n, input logic [3:0] col);
    for (int i = 0; i < n; i++) do_tick(col);
  endtask

  task automatic do_reset();
    collision_vec = 4'b0000;
    game_en       = 1'b0;
    pause         = 1'b0;
    rst           = 1'b1;
    @(negedge clk);
    rst           = 1'b0;
    lfsr_m        = 16'hACE1;
  endtask

  task automatic test_reset();
    collision_vec = 4'b0000;
    game_en       = 1'b0;
    pause         = 1'b0;
    rst           = 1'b1;
    @(negedge clk);
    tests_run++; if (obs_active !== 4'b0) begin tests_failed++; $display("FAIL reset_active got=%b exp=0000", obs_active); end
    tests_run++; if (obs_hit !== 4'b0) begin tests_failed++; $display("FAIL reset_hit got=%b exp=0000", obs_hit); end
    tests_run++; if (obs_x !== 40'd0) begin tests_failed++; $display("FAIL reset_x got=%h exp=0", obs_x); end
    tests_run++; if (obs_y !== 40'd0) begin tests_failed++; $display("FAIL reset_y got=%h exp=0", obs_y); end
    tests_run++; if (hit_pulse !== 1'b0) begin tests_failed++; $display("FAIL reset_pulse got=%b exp=0", hit_pulse); end
    tests_run++; if (hit_count !== 8'd0) begin tests_failed++; $display("FAIL reset_count got=%0d exp=0", hit_count); end
    rst    = 1'b0;
    lfsr_m = 16'hACE1;
  endtask

  int sy0;

  task automatic test_first_spawn();
    ticks(63, 4'b0000);
    tests_run++; if (obs_active !== 4'b0000) begin tests_failed++; $display("FAIL pre_spawn_active got=%b exp=0000", obs_active); end
    sy0 = spawn_y(lfsr_m);
    do_tick(4'b0000);
    tests_run++; if (obs_active !== 4'b0001) begin tests_failed++; $display("FAIL spawn_active got=%b exp=0001", obs_active); end
    tests_run++; if (obs_x[9:0] !== 10'd610) begin tests_failed++; $display("FAIL spawn_x got=%0d exp=610", obs_x[9:0]); end
    tests_run++; if (obs_y[9:0] !== 10'(sy0)) begin tests_failed++; $display("FAIL spawn_y got=%0d exp=%0d", obs_y[9:0], sy0); end
    tests_run++; if (obs_x[39:10] !== 30'd0 || obs_y[39:10] !== 30'd0) begin tests_failed++; $display("FAIL spawn_others got=%h/%h exp=0", obs_x[39:10], obs_y[39:10]); end
  endtask

  task automatic test_motion_exit();
    int ys;
    ys = 0;
    for (int k = 1; k <= 128; k++) begin
      if (k == 128) ys = spawn_y(lfsr_m);
      do_tick(4'b0000);
      if (k <= 122) begin
        tests_run++; if (obs_x[9:0] !== 10'(610 - 5*k)) begin tests_failed++; $display("FAIL move_x k=%0d got=%0d exp=%0d", k, obs_x[9:0], 610 - 5*k); end
        tests_run++; if (obs_y[9:0] !== 10'(bounce_y(sy0, k))) begin tests_failed++; $display("FAIL move_y k=%0d got=%0d exp=%0d", k, obs_y[9:0], bounce_y(sy0, k)); end
        tests_run++; if (obs_y[9:0] < 10'd50 || obs_y[9:0] > 10'd110) begin tests_failed++; $display("FAIL move_y_band k=%0d got=%0d exp=50..110", k, obs_y[9:0]); end
        tests_run++; if (obs_active[0] !== 1'b1) begin tests_failed++; $display("FAIL move_active k=%0d got=%b exp=1", k, obs_active[0]); end
      end
      if (k == 64) begin
        tests_run++; if (obs_active !== 4'b0011 || obs_x[19:10] !== 10'd610) begin tests_failed++; $display("FAIL second_spawn got=%b/%0d exp=0011/610", obs_active, obs_x[19:10]); end
      end
      if (k == 123) begin
        tests_run++; if (obs_active[0] !== 1'b0) begin tests_failed++; $display("FAIL edge_exit got=%b exp=0", obs_active[0]); end
      end
      if (k == 128) begin
        tests_run++; if (obs_active !== 4'b0011) begin tests_failed++; $display("FAIL respawn_lowest got=%b exp=0011", obs_active); end
        tests_run++; if (obs_x[9:0] !== 10'd610 || obs_y[9:0] !== 10'(ys)) begin tests_failed++; $display("FAIL respawn_pos got=%0d,%0d exp=610,%0d", obs_x[9:0], obs_y[9:0], ys); end
      end
    end
  endtask

  task automatic test_hit();
    int ys;
    int yh;
    do_reset();
    ticks(63, 4'b0000);
    ys = spawn_y(lfsr_m);
    do_tick(4'b0000);
    ticks(9, 4'b0000);
    do_tick(4'b0001);
    yh = bounce_y(ys, 9);
    tests_run++; if (obs_hit !== 4'b0001 || obs_active !== 4'b0001) begin tests_failed++; $display("FAIL hit_enter got=%b/%b exp=0001/0001", obs_hit, obs_active); end
    tests_run++; if (hit_pulse !== 1'b1) begin tests_failed++; $display("FAIL hit_pulse_high got=%b exp=1", hit_pulse); end
    tests_run++; if (hit_count !== 8'd1) begin tests_failed++; $display("FAIL hit_count got=%0d exp=1", hit_count); end
    tests_run++; if (obs_x[9:0] !== 10'd565 || obs_y[9:0] !== 10'(yh)) begin tests_failed++; $display("FAIL hit_pos got=%0d,%0d exp=565,%0d", obs_x[9:0], obs_y[9:0], yh); end
    @(negedge clk);
    tests_run++; if (hit_pulse !== 1'b0) begin tests_failed++; $display("FAIL hit_pulse_width got=%b exp=0", hit_pulse); end
    ticks(7, 4'b0001);
    tests_run++; if (obs_hit !== 4'b0001) begin tests_failed++; $display("FAIL hit_hold got=%b exp=0001", obs_hit); end
    tests_run++; if (obs_x[9:0] !== 10'd565 || obs_y[9:0] !== 10'(yh)) begin tests_failed++; $display("FAIL hit_freeze got=%0d,%0d exp=565,%0d", obs_x[9:0], obs_y[9:0], yh); end
    tests_run++; if (hit_count !== 8'd1 || hit_pulse !== 1'b0) begin tests_failed++; $display("FAIL hit_ignore_col got=%0d/%b exp=1/0", hit_count, hit_pulse); end
    do_tick(4'b0001);
    tests_run++; if (obs_hit !== 4'b0000 || obs_active !== 4'b0000) begin tests_failed++; $display("FAIL hit_release got=%b/%b exp=0000/0000", obs_hit, obs_active); end
    tests_run++; if (hit_count !== 8'd1) begin tests_failed++; $display("FAIL idle_ignore_col got=%0d exp=1", hit_count); end
  endtask

  task automatic test_double_hit();
    do_reset();
    ticks(128, 4'b0000);
    do_tick(4'b0011);
    tests_run++; if (obs_hit !== 4'b0011) begin tests_failed++; $display("FAIL double_hit got=%b exp=0011", obs_hit); end
    tests_run++; if (hit_count !== 8'd2) begin tests_failed++; $display("FAIL double_count got=%0d exp=2", hit_count); end
    tests_run++; if (hit_pulse !== 1'b1) begin tests_failed++; $display("FAIL double_pulse got=%b exp=1", hit_pulse); end
    @(negedge clk);
    tests_run++; if (hit_pulse !== 1'b0 || hit_count !== 8'd2) begin tests_failed++; $display("FAIL double_single_pulse got=%b/%0d exp=0/2", hit_pulse, hit_count); end
  endtask

  task automatic test_full_array();
    do_reset();
    ticks(16, 4'b0000);
    tests_run++; if (b_active !== 4'b1111) begin tests_failed++; $display("FAIL full_fill got=%b exp=1111", b_active); end
    ticks(4, 4'b0000);
    tests_run++; if (b_active !== 4'b1111 || b_x[9:0] !== 10'd594 || b_x[39:30] !== 10'd606) begin tests_failed++; $display("FAIL full_drop got=%b/%0d/%0d exp=1111/594/606", b_active, b_x[9:0], b_x[39:30]); end
    do_tick(4'b0001);
    tests_run++; if (b_hit !== 4'b0001 || b_x[9:0] !== 10'd594) begin tests_failed++; $display("FAIL full_hit got=%b/%0d exp=0001/594", b_hit, b_x[9:0]); end
    ticks(8, 4'b0000);
    tests_run++; if (b_active !== 4'b1110 || b_hit !== 4'b0000) begin tests_failed++; $display("FAIL full_freed got=%b/%b exp=1110/0000", b_active, b_hit); end
    ticks(2, 4'b0000);
    tests_run++; if (b_active !== 4'b1110) begin tests_failed++; $display("FAIL full_wait got=%b exp=1110", b_active); end
    do_tick(4'b0000);
    tests_run++; if (b_active !== 4'b1111 || b_x[9:0] !== 10'd610) begin tests_failed++; $display("FAIL full_wrap_spawn got=%b/%0d exp=1111/610", b_active, b_x[9:0]); end
  endtask

  task automatic test_saturate();
    do_reset();
    ticks(1017, 4'b1111);
    tests_run++; if (b_count !== 8'd254) begin tests_failed++; $display("FAIL sat_pre got=%0d exp=254", b_count); end
    ticks(7, 4'b0000);
    tests_run++; if (b_count !== 8'd254) begin tests_failed++; $display("FAIL sat_hold got=%0d exp=254", b_count); end
    do_tick(4'b1111);
    tests_run++; if (b_count !== 8'd255 || b_pulse !== 1'b1) begin tests_failed++; $display("FAIL sat_cap got=%0d/%b exp=255/1", b_count, b_pulse); end
    ticks(8, 4'b1111);
    tests_run++; if (b_count !== 8'd255) begin tests_failed++; $display("FAIL sat_stay got=%0d exp=255", b_count); end
  endtask

  task automatic test_pause_reset();
    int ys;
    do_reset();
    ticks(63, 4'b0000);
    ys = spawn_y(lfsr_m);
    do_tick(4'b0000);
    pause = 1'b1;
    ticks(100, 4'b0001);
    tests_run++; if (obs_active !== 4'b0001 || obs_hit !== 4'b0000) begin tests_failed++; $display("FAIL pause_state got=%b/%b exp=0001/0000", obs_active, obs_hit); end
    tests_run++; if (obs_x[9:0] !== 10'd610 || obs_y[9:0] !== 10'(ys)) begin tests_failed++; $display("FAIL pause_pos got=%0d,%0d exp=610,%0d", obs_x[9:0], obs_y[9:0], ys); end
    tests_run++; if (hit_count !== 8'd0) begin tests_failed++; $display("FAIL pause_count got=%0d exp=0", hit_count); end
    pause = 1'b0;
    ticks(63, 4'b0000);
    tests_run++; if (obs_active !== 4'b0001 || obs_x[9:0] !== 10'd295) begin tests_failed++; $display("FAIL pause_counter got=%b/%0d exp=0001/295", obs_active, obs_x[9:0]); end
    ys = spawn_y(lfsr_m);
    do_tick(4'b0000);
    tests_run++; if (obs_active !== 4'b0011 || obs_x[19:10] !== 10'd610 || obs_y[19:10] !== 10'(ys)) begin tests_failed++; $display("FAIL pause_lfsr got=%b/%0d/%0d exp=0011/610/%0d", obs_active, obs_x[19:10], obs_y[19:10], ys); end
    ticks(5, 4'b0000);
    #2 rst = 1'b1;
    #1;
    tests_run++; if (obs_active !== 4'b0 || obs_x !== 40'd0 || obs_y !== 40'd0) begin tests_failed++; $display("FAIL async_reset got=%b/%h/%h exp=0/0/0", obs_active, obs_x, obs_y); end
    @(negedge clk);
    tests_run++; if (obs_active !== 4'b0 || obs_hit !== 4'b0 || hit_pulse !== 1'b0 || hit_count !== 8'd0) begin tests_failed++; $display("FAIL reset_edge got=%b/%b/%b/%0d exp=0/0/0/0", obs_active, obs_hit, hit_pulse, hit_count); end
    rst    = 1'b0;
    lfsr_m = 16'hACE1;
    ticks(63, 4'b0000);
    tests_run++; if (obs_active !== 4'b0000) begin tests_failed++; $display("FAIL post_reset_early got=%b exp=0000", obs_active); end
    ys = spawn_y(lfsr_m);
    do_tick(4'b0000);
    tests_run++; if (obs_active !== 4'b0001 || obs_x[9:0] !== 10'd610 || obs_y[9:0] !== 10'(ys)) begin tests_failed++; $display("FAIL post_reset_spawn got=%b/%0d/%0d exp=0001/610/%0d", obs_active, obs_x[9:0], obs_y[9:0], ys); end
  endtask

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    rst           = 1'b1;
    game_en       = 1'b0;
    pause         = 1'b0;
    collision_vec = 4'b0000;
    lfsr_m        = 16'hACE1;
    @(negedge clk);
    test_reset();
    test_first_spawn();
    test_motion_exit();
    test_hit();
    test_double_hit();
    test_full_array();
    test_saturate();
    test_pause_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
